// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU types: word type, immediate width, next-PC select encoding and
// fetch-stage FSM states.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int IMM_W  = 16;

    typedef logic [WORD_W-1:0] word_t;

    // Next-PC select driven by the control unit. Codes 4..7 fall back to PC+4.
    typedef enum logic [2:0] {
        PC_SEQ    = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JUMP   = 3'd2,
        PC_JR     = 3'd3
    } pcsrc_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        DWAIT = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// ---------------------------------------------------------------------------
// next_pc_calc
// Pure combinational next-PC selection for the fetch stage.
// Ports:
//   pc_plus4   in  32  PC+4 of the executing instruction
//   jaddr      in  26  jump index field of the instruction register
//   pcsrc      in  3   next-PC select (pcsrc_t encoding)
//   br_taken   in  1   branch condition from the datapath
//   imm        in  16  branch word offset
//   jr_target  in  32  register value for JR
//   next_pc    out 32  selected next PC
// All additions wrap modulo 2^32.
// ---------------------------------------------------------------------------
module next_pc_calc
    import cpu_types_pkg::*;
(
    input  word_t             pc_plus4,
    input  logic [25:0]       jaddr,
    input  logic [2:0]        pcsrc,
    input  logic              br_taken,
    input  logic [IMM_W-1:0]  imm,
    input  word_t             jr_target,
    output word_t             next_pc
);

    word_t w_br_offset;
    word_t w_br_target;

    // Sign-extended word offset, scaled to bytes.
    assign w_br_offset = {{14{imm[IMM_W-1]}}, imm, 2'b00};
    assign w_br_target = pc_plus4 + w_br_offset;

    always_comb begin
        next_pc = pc_plus4;
        case (pcsrc)
            PC_SEQ:    next_pc = pc_plus4;
            PC_BRANCH: next_pc = br_taken ? w_br_target : pc_plus4;
            PC_JUMP:   next_pc = {pc_plus4[31:28], jaddr, 2'b00};
            // Low two bits cleared so a misaligned register value still
            // lands on a word boundary.
            PC_JR:     next_pc = jr_target & 32'hFFFF_FFFC;
            default:   next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: owns the PC, requests words from the icache,
// latches them into the instruction register feeding the control unit, waits
// out data accesses and parks on HALT until reset.
// Ports:
//   CLK        in  1   clock, all state on posedge
//   nRST       in  1   synchronous active-low reset
//   ihit       in  1   icache word valid (used only in FETCH)
//   iload      in  32  icache word
//   dhit       in  1   data access complete (used only in EXEC/DWAIT)
//   dREN/dWEN  in  1   executing instruction reads/writes memory
//   halt       in  1   executing instruction is HALT
//   PCSrc      in  3   next-PC select
//   br_taken   in  1   branch condition
//   imm        in  16  branch offset
//   jr_target  in  32  JR target register value
//   iREN       out 1   icache read request
//   iaddr      out 32  icache address (= PC)
//   imemload   out 32  instruction register
//   instr_vld  out 1   instruction register holds an executing instruction
//   pc_plus4   out 32  PC+4 (JAL link value)
//   halted     out 1   processor stopped
//   dbg_state  out 2   current FSM state (fetch_state_t encoding)
// Handshake: a fetch completes on the first posedge in FETCH with ihit=1; a
// data access completes on the first posedge in EXEC/DWAIT with dhit=1. The
// request lines (iREN, dREN/dWEN) stay asserted until then; there is no
// back-pressure beyond that.
// ---------------------------------------------------------------------------
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
)
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        dhit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic        halt,
    input  logic [2:0]  PCSrc,
    input  logic        br_taken,
    input  logic [15:0] imm,
    input  logic [31:0] jr_target,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] imemload,
    output logic        instr_vld,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic [1:0]  dbg_state
);

    fetch_state_t r_state;
    word_t        r_pc;
    word_t        r_ir;
    word_t        w_pc_plus4;
    word_t        w_next_pc;
    logic         w_mem_op;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_mem_op   = dREN | dWEN;

    next_pc_calc u_next_pc (
        .pc_plus4  (w_pc_plus4),
        .jaddr     (r_ir[25:0]),
        .pcsrc     (PCSrc),
        .br_taken  (br_taken),
        .imm       (imm),
        .jr_target (jr_target),
        .next_pc   (w_next_pc)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= FETCH;
            r_pc    <= PC_INIT;
            r_ir    <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (ihit) begin
                        r_ir    <= iload;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    // HALT takes priority over any pending data access.
                    if (halt) begin
                        r_state <= HALT;
                    end else if (w_mem_op && !dhit) begin
                        r_state <= DWAIT;
                    end else begin
                        r_pc    <= w_next_pc;
                        r_state <= FETCH;
                    end
                end
                DWAIT: begin
                    if (dhit) begin
                        r_pc    <= w_next_pc;
                        r_state <= FETCH;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    always_comb begin
        iREN      = 1'b0;
        instr_vld = 1'b0;
        halted    = 1'b0;
        case (r_state)
            FETCH:   iREN      = 1'b1;
            EXEC:    instr_vld = 1'b1;
            DWAIT:   instr_vld = 1'b1;
            HALT:    halted    = 1'b1;
            default: iREN      = 1'b0;
        endcase
        iaddr     = r_pc;
        imemload  = r_ir;
        pc_plus4  = w_pc_plus4;
        dbg_state = r_state;
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import cpu_types_pkg::*;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, dREN, dWEN, halt, br_taken;
    logic [31:0] iload, jr_target;
    logic [2:0]  PCSrc;
    logic [15:0] imm;
    logic        iREN, instr_vld, halted;
    logic [31:0] iaddr, imemload, pc_plus4;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model state: PC of the instruction about to be fetched.
    logic [31:0] model_pc;
    logic [31:0] exp_q[$];

    fetch_unit #(.PC_INIT(PC_INIT)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .dhit(dhit),
        .dREN(dREN), .dWEN(dWEN), .halt(halt), .PCSrc(PCSrc),
        .br_taken(br_taken), .imm(imm), .jr_target(jr_target),
        .iREN(iREN), .iaddr(iaddr), .imemload(imemload),
        .instr_vld(instr_vld), .pc_plus4(pc_plus4), .halted(halted),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ir,
                                             input logic [2:0] src, input logic taken,
                                             input logic [15:0] off, input logic [31:0] jr);
        int          byte_off;
        logic [31:0] seq;
        seq = pc + 32'd4;
        case (src)
            3'd1: begin
                byte_off = int'($signed(off)) * 4;
                return taken ? seq + 32'(byte_off) : seq;
            end
            3'd2: return (seq & 32'hF000_0000) | ({6'b0, ir[25:0]} * 32'd4);
            3'd3: return jr - (jr % 32'd4);
            default: return seq;
        endcase
    endfunction

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        ihit = 0; dhit = 0; dREN = 0; dWEN = 0; halt = 0; br_taken = 0;
        iload = $urandom; PCSrc = 3'd0; imm = 16'($urandom); jr_target = $urandom;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        nRST = 0; ihit = 1; dhit = 1; halt = 1; dREN = 1;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1;
        idle_inputs();
        model_pc = PC_INIT;
    endtask

    // One full instruction: FETCH (with ihit delay), EXEC, optional DWAIT.
    // Called at a negedge with the DUT in FETCH; returns at a negedge in FETCH.
    task automatic run_instr(input logic [31:0] w, input logic [2:0] src, input logic taken,
                             input logic [15:0] off, input logic [31:0] jr,
                             input logic mem_rd, input logic mem_wr,
                             input int ihit_delay, input int dwaits);
        logic [31:0] exp_pc;
        for (int i = 0; i <= ihit_delay; i++) begin
            checks++;
            if (iREN !== 1'b1 || iaddr !== model_pc || instr_vld !== 1'b0) begin
                errors++;
                $display("FAIL fetch_wait: iREN=%b iaddr=%h vld=%b, required iREN=1 iaddr=%h vld=0",
                         iREN, iaddr, instr_vld, model_pc);
            end
            ihit = (i == ihit_delay);
            iload = (i == ihit_delay) ? w : $urandom;
            dhit = $urandom_range(0, 1);
            @(negedge CLK);
        end
        ihit = 0; iload = $urandom;
        checks++;
        if (imemload !== w || instr_vld !== 1'b1 || iREN !== 1'b0 || pc_plus4 !== model_pc + 32'd4
            || dbg_state !== EXEC) begin
            errors++;
            $display("FAIL exec: ir=%h vld=%b iREN=%b pcp4=%h st=%0d, required ir=%h vld=1 iREN=0 pcp4=%h st=%0d",
                     imemload, instr_vld, iREN, pc_plus4, dbg_state, w, model_pc + 32'd4, EXEC);
        end
        PCSrc = src; br_taken = taken; imm = off; jr_target = jr;
        dREN = mem_rd; dWEN = mem_wr;
        dhit = !(mem_rd || mem_wr) ? 1'($urandom_range(0, 1)) : (dwaits == 0);
        exp_q.push_back(ref_next(model_pc, w, src, taken, off, jr));
        if ((mem_rd || mem_wr) && dwaits > 0) begin
            for (int i = 0; i < dwaits; i++) begin
                @(negedge CLK);
                checks++;
                if (dbg_state !== DWAIT || iREN !== 1'b0 || instr_vld !== 1'b1 || iaddr !== model_pc
                    || imemload !== w) begin
                    errors++;
                    $display("FAIL dwait: st=%0d iREN=%b vld=%b iaddr=%h ir=%h, required st=%0d iREN=0 vld=1 iaddr=%h ir=%h",
                             dbg_state, iREN, instr_vld, iaddr, imemload, DWAIT, model_pc, w);
                end
                dhit = (i == dwaits - 1);
            end
        end
        @(negedge CLK);
        idle_inputs();
        exp_pc = exp_q.pop_front();
        model_pc = exp_pc;
        checks++;
        if (iaddr !== exp_pc || iREN !== 1'b1 || instr_vld !== 1'b0 || dbg_state !== FETCH) begin
            errors++;
            $display("FAIL next_pc: iaddr=%h iREN=%b vld=%b st=%0d, required iaddr=%h iREN=1 vld=0 st=%0d",
                     iaddr, iREN, instr_vld, dbg_state, exp_pc, FETCH);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if (iREN !== 1'b1 || iaddr !== PC_INIT || imemload !== 32'h0 || instr_vld !== 1'b0
            || pc_plus4 !== PC_INIT + 32'd4 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset: iREN=%b iaddr=%h ir=%h vld=%b pcp4=%h halted=%b, required 1 %h 0 0 %h 0",
                     iREN, iaddr, imemload, instr_vld, pc_plus4, halted, PC_INIT, PC_INIT + 32'd4);
        end
    endtask

    task automatic test_seq();
        run_instr(32'h2001_0005, 3'd0, 0, 16'h0, 32'h0, 0, 0, 0, 0);
        checks++;
        if (iaddr !== 32'h0000_0004) begin
            errors++;
            $display("FAIL seq_first: iaddr=%h, required 00000004", iaddr);
        end
    endtask

    task automatic test_dwait();
        run_instr($urandom, 3'd0, 0, 16'h0, 32'h0, 0, 1, 0, 3);
        run_instr($urandom, 3'd0, 0, 16'h0, 32'h0, 1, 0, 1, 1);
        run_instr($urandom, 3'd0, 0, 16'h0, 32'h0, 0, 1, 0, 0);
        run_instr($urandom, 3'd0, 0, 16'h0, 32'h0, 1, 0, 2, 0);
    endtask

    task automatic test_branch();
        apply_reset();
        for (int i = 0; i < 4; i++) run_instr($urandom, 3'd0, 0, 16'h0, 32'h0, 0, 0, 0, 0);
        run_instr($urandom, 3'd1, 1, 16'hFFFE, 32'h0, 0, 0, 0, 0);
        checks++;
        if (iaddr !== 32'h0000_000C) begin
            errors++;
            $display("FAIL branch_taken: iaddr=%h, required 0000000c", iaddr);
        end
        run_instr($urandom, 3'd0, 0, 16'h0, 32'h0, 0, 0, 0, 0);
        run_instr($urandom, 3'd1, 0, 16'hFFFE, 32'h0, 0, 0, 0, 0);
        checks++;
        if (iaddr !== 32'h0000_0014) begin
            errors++;
            $display("FAIL branch_not_taken: iaddr=%h, required 00000014", iaddr);
        end
        // Branch taken through a DWAIT: offset applied at the end of the wait.
        run_instr($urandom, 3'd1, 1, 16'h0010, 32'h0, 1, 0, 0, 2);
    endtask

    task automatic test_jump_jr();
        run_instr($urandom, 3'd3, 0, 16'h0, 32'h4000_0000, 0, 0, 0, 0);
        run_instr(32'h0800_0040, 3'd2, 0, 16'h0, 32'h0, 0, 0, 0, 0);
        checks++;
        if (iaddr !== 32'h4000_0100) begin
            errors++;
            $display("FAIL jump: iaddr=%h, required 40000100", iaddr);
        end
        run_instr($urandom, 3'd3, 0, 16'h0, 32'h0000_0103, 0, 0, 0, 0);
        checks++;
        if (iaddr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL jr_align: iaddr=%h, required 00000100", iaddr);
        end
        run_instr($urandom, 3'd3, 0, 16'h0, 32'hFFFF_FFFC, 0, 0, 0, 0);
        run_instr($urandom, 3'd0, 0, 16'h0, 32'h0, 0, 0, 0, 0);
        checks++;
        if (iaddr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL pc_wrap: iaddr=%h, required 00000000", iaddr);
        end
    endtask

    task automatic test_halt();
        run_instr($urandom, 3'd0, 0, 16'h0, 32'h0, 0, 0, 0, 0);
        run_instr($urandom, 3'd0, 0, 16'h0, 32'h0, 0, 0, 0, 0);
        // Fetch one more word, then halt with a pending read.
        ihit = 1; iload = 32'hFC00_0000;
        @(negedge CLK);
        ihit = 0;
        halt = 1; dREN = 1; dhit = 0; PCSrc = 3'd3; jr_target = 32'h1234_5670;
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            checks++;
            if (halted !== 1'b1 || iREN !== 1'b0 || instr_vld !== 1'b0 || iaddr !== model_pc) begin
                errors++;
                $display("FAIL halt_cycle%0d: halted=%b iREN=%b vld=%b iaddr=%h, required 1 0 0 %h",
                         i, halted, iREN, instr_vld, iaddr, model_pc);
            end
            halt = 1'($urandom_range(0, 1)); ihit = 1'($urandom_range(0, 1));
            dhit = 1'($urandom_range(0, 1)); iload = $urandom;
        end
        nRST = 0;
        @(negedge CLK);
        nRST = 1;
        idle_inputs();
        model_pc = PC_INIT;
        checks++;
        if (iaddr !== PC_INIT || halted !== 1'b0 || iREN !== 1'b1 || imemload !== 32'h0) begin
            errors++;
            $display("FAIL halt_reset: iaddr=%h halted=%b iREN=%b ir=%h, required %h 0 1 0",
                     iaddr, halted, iREN, imemload, PC_INIT);
        end
    endtask

    task automatic test_reset_in_dwait();
        run_instr($urandom, 3'd0, 0, 16'h0, 32'h0, 0, 0, 0, 0);
        ihit = 1; iload = 32'hAC22_0008;
        @(negedge CLK);
        ihit = 0; dWEN = 1; dhit = 0;
        @(negedge CLK);
        checks++;
        if (dbg_state !== DWAIT || instr_vld !== 1'b1) begin
            errors++;
            $display("FAIL rst_dwait_pre: st=%0d vld=%b, required st=%0d vld=1", dbg_state, instr_vld, DWAIT);
        end
        dhit = 1; nRST = 0;
        @(negedge CLK);
        nRST = 1;
        idle_inputs();
        model_pc = PC_INIT;
        checks++;
        if (dbg_state !== FETCH || iaddr !== PC_INIT || imemload !== 32'h0 || iREN !== 1'b1) begin
            errors++;
            $display("FAIL rst_dwait: st=%0d iaddr=%h ir=%h iREN=%b, required st=%0d %h 0 1",
                     dbg_state, iaddr, imemload, iREN, FETCH, PC_INIT);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic mem;
            mem = 1'($urandom_range(0, 1));
            run_instr($urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      16'($urandom), $urandom, mem & 1'($urandom_range(0, 1)), mem,
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end
    endtask

    // ---------------- main ----------------
    initial begin
        nRST = 1;
        idle_inputs();
        model_pc = PC_INIT;
        test_reset();
        test_seq();
        test_dwait();
        test_branch();
        test_jump_jr();
        test_halt();
        test_reset_in_dwait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
